// File: rtl/dff_pipeline.sv
// dff_pipeline: WIDTH-bit, DEPTH-stage registered delay line with per-stage
// valid tags, global stall, flush, occupancy count and a registered Qbar.
module dff_pipeline #(
  parameter int unsigned     WIDTH       = 8,
  parameter int unsigned     DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       d_valid,
  input  logic [WIDTH-1:0]           D,
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           Qbar,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic [WIDTH-1:0] qbar_q;
  logic [WIDTH-1:0] qbar_d;

  // Next-state: flush clears tags only; advance shifts data and tags together.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    valid_d = valid_q;
    occ_d   = occ_q;
    qbar_d  = qbar_q;

    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
    end else if (enable) begin
      data_d[0]  = D;
      valid_d[0] = d_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // Complement is computed from the value Q is about to take, so
      // Qbar tracks ~Q on every cycle without a combinational output path.
      qbar_d = ~data_d[DEPTH-1];
      // Range 0..DEPTH holds by construction; modulo arithmetic is exact.
      occ_d  = occ_q + OCC_W'(d_valid) - OCC_W'(valid_q[DEPTH-1]);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VALUE;
      end
      valid_q <= '0;
      occ_q   <= '0;
      qbar_q  <= ~RESET_VALUE;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
      occ_q   <= occ_d;
      qbar_q  <= qbar_d;
    end
  end

  assign Q         = data_q[DEPTH-1];
  assign q_valid   = valid_q[DEPTH-1];
  assign Qbar      = qbar_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_dff_pipeline.sv
// Self-checking bench for dff_pipeline (WIDTH=8, DEPTH=3, RESET_VALUE=A5).
module tb_dff_pipeline;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 3;
  localparam logic [WIDTH-1:0] RV = 8'hA5;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             valid;
  } entry_t;

  logic             clock;
  logic             reset_n;
  logic             enable;
  logic             flush;
  logic             d_valid;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic             q_valid;
  logic [OCC_W-1:0] occupancy;

  entry_t sb[$];
  int checks = 0;
  int errors = 0;

  dff_pipeline #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .RESET_VALUE(RV)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .flush    (flush),
    .d_valid  (d_valid),
    .D        (D),
    .Q        (Q),
    .Qbar     (Qbar),
    .q_valid  (q_valid),
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard holds DEPTH entries; the front is the word currently at Q.
  task automatic model_reset();
    entry_t e;
    e.data  = RV;
    e.valid = 1'b0;
    sb.delete();
    for (int i = 0; i < int'(DEPTH); i++) sb.push_back(e);
  endtask

  task automatic check_outputs(input string tag);
    entry_t exp_e;
    logic [OCC_W-1:0] exp_occ;
    int cnt;
    exp_e = sb[0];
    cnt = 0;
    for (int i = 0; i < sb.size(); i++) if (sb[i].valid) cnt++;
    exp_occ = OCC_W'(cnt);

    checks++;
    assert (Q === exp_e.data) else begin
      errors++;
      $error("FAIL %s Q observed=%h expected=%h", tag, Q, exp_e.data);
    end
    checks++;
    assert (Qbar === ~exp_e.data) else begin
      errors++;
      $error("FAIL %s Qbar observed=%h expected=%h", tag, Qbar, ~exp_e.data);
    end
    checks++;
    assert (q_valid === exp_e.valid) else begin
      errors++;
      $error("FAIL %s q_valid observed=%b expected=%b", tag, q_valid, exp_e.valid);
    end
    checks++;
    assert (occupancy === exp_occ) else begin
      errors++;
      $error("FAIL %s occupancy observed=%0d expected=%0d", tag, occupancy, exp_occ);
    end
  endtask

  // One clock edge: drive inputs, update scoreboard, sample 1 time unit later.
  task automatic step(input string tag, input logic rn, input logic en,
                      input logic fl, input logic dv, input logic [WIDTH-1:0] din);
    entry_t e;
    reset_n = rn;
    enable  = en;
    flush   = fl;
    d_valid = dv;
    D       = din;
    @(posedge clock);
    if (!rn) begin
      model_reset();
    end else if (fl) begin
      for (int i = 0; i < sb.size(); i++) sb[i].valid = 1'b0;
    end else if (en) begin
      e.data  = din;
      e.valid = dv;
      sb.push_back(e);
      void'(sb.pop_front());
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    flush   = 1'b0;
    d_valid = 1'b0;
    D       = '0;
    model_reset();

    // Reset with random data/enable.
    step("reset0", 1'b0, 1'($urandom), 1'b0, 1'($urandom), 8'($urandom));
    step("reset1", 1'b0, 1'($urandom), 1'b0, 1'($urandom), 8'($urandom));

    // Streaming 01..04 then drain.
    step("stream01", 1'b1, 1'b1, 1'b0, 1'b1, 8'h01);
    step("stream02", 1'b1, 1'b1, 1'b0, 1'b1, 8'h02);
    step("stream03", 1'b1, 1'b1, 1'b0, 1'b1, 8'h03);
    step("stream04", 1'b1, 1'b1, 1'b0, 1'b1, 8'h04);
    for (int i = 0; i < 3; i++) step("drain", 1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom));

    // Stall: two words, four held cycles with junk inputs, then resume.
    step("stall_ld11", 1'b1, 1'b1, 1'b0, 1'b1, 8'h11);
    step("stall_ld22", 1'b1, 1'b1, 1'b0, 1'b1, 8'h22);
    for (int i = 0; i < 4; i++) step("stall_hold", 1'b1, 1'b0, 1'b0, 1'($urandom), 8'($urandom));
    step("stall_res0", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    assert (Q === 8'h11 && q_valid === 1'b1) else begin
      errors++;
      $error("FAIL stall_latency Q observed=%h/%b expected=11/1", Q, q_valid);
    end
    step("stall_res1", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step("stall_res2", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    // Mixed valid pattern.
    step("mix_c0", 1'b1, 1'b1, 1'b0, 1'b1, 8'hC0);
    step("mix_c1", 1'b1, 1'b1, 1'b0, 1'b0, 8'hC1);
    step("mix_c2", 1'b1, 1'b1, 1'b0, 1'b1, 8'hC2);
    checks++;
    assert (occupancy === OCC_W'(2)) else begin
      errors++;
      $error("FAIL mix_occ observed=%0d expected=2", occupancy);
    end
    for (int i = 0; i < 3; i++) step("mix_drain", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    // Flush with enable: FF must never emerge valid.
    step("fl_31", 1'b1, 1'b1, 1'b0, 1'b1, 8'h31);
    step("fl_32", 1'b1, 1'b1, 1'b0, 1'b1, 8'h32);
    step("fl_33", 1'b1, 1'b1, 1'b0, 1'b1, 8'h33);
    step("flush", 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    checks++;
    assert (Q === 8'h31 && occupancy === '0) else begin
      errors++;
      $error("FAIL flush_hold Q/occ observed=%h/%0d expected=31/0", Q, occupancy);
    end
    for (int i = 0; i < 4; i++) step("fl_after", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step("fl_load", 1'b1, 1'b1, 1'b0, 1'b1, 8'h44);
    step("flush_noen", 1'b1, 1'b0, 1'b1, 1'b1, 8'h55);

    // Mid-operation reset with flush and enable asserted.
    step("mr_a", 1'b1, 1'b1, 1'b0, 1'b1, 8'h61);
    step("mr_b", 1'b1, 1'b1, 1'b0, 1'b1, 8'h62);
    step("mid_reset", 1'b0, 1'b1, 1'b1, 1'b1, 8'h63);
    step("post01", 1'b1, 1'b1, 1'b0, 1'b1, 8'h01);
    step("post02", 1'b1, 1'b1, 1'b0, 1'b1, 8'h02);
    step("post03", 1'b1, 1'b1, 1'b0, 1'b1, 8'h03);
    step("post04", 1'b1, 1'b1, 1'b0, 1'b1, 8'h04);

    // Random mix of all controls.
    for (int i = 0; i < 40; i++) begin
      step("rand", ($urandom_range(0, 19) != 0), 1'($urandom),
           ($urandom_range(0, 9) == 0), 1'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_pipeline.md
Name: dff_pipeline

Overview:
Parametrised successor to the team's single-bit D flip-flop with complementary output. It is a WIDTH-bit, DEPTH-stage registered delay line with per-stage valid tags, global stall (enable), flush, and an occupancy counter. The final stage drives Q and a registered complement Qbar. It is used wherever datapath signals need fixed-latency alignment with valid tracking.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 3, number of register stages = latency in enabled cycles (>=1)
RESET_VALUE, 0, WIDTH-bit value loaded into every data stage on reset

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
enable  input  1  1 = pipeline advances this edge; 0 = all state holds
flush  input  1  1 = clear all valid tags and occupancy (data registers hold)
d_valid  input  1  valid tag for D
D  input  WIDTH  input data
Q  output  WIDTH  data of stage DEPTH-1
Qbar  output  WIDTH  bitwise complement of Q, registered
q_valid  output  1  valid tag of stage DEPTH-1
occupancy  output  $clog2(DEPTH+1)  number of stages currently holding valid=1

Behaviour:
- Single clock domain: clock. Reset is synchronous and active-low on reset_n. All state changes occur only on posedge clock.
- Internal state:
  - data stages s[0..DEPTH-1], WIDTH bits each
  - valid bits v[0..DEPTH-1]
  - occupancy counter
  - Qbar register
- Q = s[DEPTH-1] and q_valid = v[DEPTH-1], driven directly from registers (no combinational path from inputs to outputs).
- Priority per edge: reset_n=0 > flush=1 > enable=1 > hold.
- Reset (reset_n=0 at edge):
  - all s[i] = RESET_VALUE
  - all v[i] = 0
  - Q = RESET_VALUE, Qbar = ~RESET_VALUE
  - q_valid = 0, occupancy = 0
  - Reset asserted mid-stream discards all in-flight data, regardless of enable/flush.
- Flush (reset_n=1, flush=1):
  - all v[i] = 0, occupancy = 0
  - s[i] and Qbar hold
  - D/d_valid presented that edge are discarded even if enable=1
- Advance (reset_n=1, flush=0, enable=1):
  - s[0]<=D, v[0]<=d_valid
  - s[i]<=s[i-1], v[i]<=v[i-1] for i>=1
  - Qbar <= ~(next Q), so Qbar == ~Q holds on every cycle after reset
  - Data shifts unconditionally; valid only tags it. Invalid data still propagates to Q.
- Hold (enable=0, flush=0): every register keeps its value. Inputs are ignored.
- Latency: a word accepted on enabled edge N appears on Q/q_valid after the DEPTH-th enabled edge counting from N (edge N is the first). With enable held high, that is exactly DEPTH cycles. Stall cycles add latency 1:1.
- DEPTH=1: s[0] is Q directly; latency is 1 enabled edge.
- Occupancy on an advance edge: occ_next = occ + d_valid - v[DEPTH-1].
  - Simultaneous entry and exit of valid words leaves occupancy unchanged.
  - The range 0..DEPTH is guaranteed by construction; no saturation logic is needed.
  - Occupancy must always equal popcount(v). Verification checks this as an assertion.
- No X propagation out of Q/Qbar after the first reset edge.

Test Plan:
- Reset with WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5: drive reset_n=0 for 2 edges with random D/enable -> Q=8'hA5, Qbar=8'h5A, q_valid=0, occupancy=0.
- Streaming: enable=1, d_valid=1, D=8'h01,02,03,04 on consecutive edges -> Q=8'h01 after the 3rd edge, then 02, 03, 04. Qbar=~Q each cycle. Occupancy goes 1,2,3 and stays 3.
- Stall: load 8'h11 then 8'h22, drop enable for 4 cycles, then resume -> all outputs frozen during the stall. 8'h11 reaches Q on the 3rd enabled edge, 7 cycles after capture.
- Mixed valid: d_valid pattern 1,0,1 with D=8'hC0,C1,C2 -> q_valid sequence 1,0,1 with Q=C0,C1,C2. Occupancy =2 once all three are in flight.
- Flush with enable: stream 3 valid words, then flush=1 & enable=1 & d_valid=1 & D=8'hFF -> next edge q_valid=0, occupancy=0, Q unchanged. 8'hFF never appears with q_valid=1.
- Mid-operation reset: 2 valid words in flight, reset_n=0 for 1 edge with flush=1, enable=1 -> reset state exactly as in the first scenario. Subsequent streaming behaves as in the second scenario.
